// File: rtl/aes_pkg.sv
// Shared types and helpers for the byte-serial AES round controller.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10
  } aes_mode_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KWAIT = 3'd1,
    ST_INIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_t;

  // The reserved encoding 2'b11 is folded onto the 256-bit schedule.
  function automatic aes_mode_t mode_of(input logic [1:0] m);
    case (m)
      2'b00:   mode_of = MODE_128;
      2'b01:   mode_of = MODE_192;
      default: mode_of = MODE_256;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input aes_mode_t m);
    case (m)
      MODE_128: nr_of = NR_128;
      MODE_192: nr_of = NR_192;
      default:  nr_of = NR_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_substep_cnt.sv
// 4-bit sub-step counter with clear, enable and terminal count at 15.
module aes_substep_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] cnt_o,
  output logic       tc_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == 4'd15);

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the byte-serial AES datapath: handshakes, key requests,
// sub-step select and state-register strobes for round 0 plus Nr rounds.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DRAIN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [1:0] mode_i,
  input  logic       key_ready_i,
  output logic [3:0] key_round_o,
  output logic [3:0] round_o,
  output logic [3:0] width_sel_o,
  output logic       load_sel_o,
  output logic       state_we_o,
  output logic       last_round_o,
  output logic       busy_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [3:0]  round_q, round_d;
  aes_mode_t   mode_q, mode_d;
  logic [3:0]  cnt_s;
  logic        tc_s;
  logic        cnt_clr_s;
  logic        cnt_en_s;
  logic        drain_last_s;
  logic [3:0]  nr_s;

  assign nr_s         = nr_of(mode_q);
  // One counter walks the 16 sub-steps, wraps to 0 and then times the drain.
  assign cnt_en_s     = (state_q == ST_ROUND) || (state_q == ST_DRAIN);
  assign cnt_clr_s    = !cnt_en_s || ((state_q == ST_DRAIN) && drain_last_s);
  assign drain_last_s = (cnt_s == DRAIN_LAST);

  aes_substep_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr_s),
    .en_i  (cnt_en_s),
    .cnt_o (cnt_s),
    .tc_o  (tc_s)
  );

  // Next-state, round and latched-mode logic.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          state_d = ST_KWAIT;
          mode_d  = mode_of(mode_i);
          round_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KWAIT: begin
        if (!key_ready_i) begin
          state_d = ST_KWAIT;
        end else if (round_q == 4'd0) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_INIT: begin
        state_d = ST_KWAIT;
        round_d = 4'd1;
      end
      ST_ROUND: begin
        if (tc_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_DRAIN: begin
        if (!drain_last_s) begin
          state_d = ST_DRAIN;
        end else if (round_q == nr_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_KWAIT;
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
          round_d = 4'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      mode_q  <= MODE_128;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready_o   = (state_q == ST_IDLE);
  assign key_round_o  = (state_q == ST_KWAIT) ? round_q : 4'd0;
  assign round_o      = round_q;
  assign width_sel_o  = (state_q == ST_ROUND) ? cnt_s : 4'd0;
  assign load_sel_o   = (state_q == ST_INIT);
  assign state_we_o   = (state_q == ST_INIT) || ((state_q == ST_DRAIN) && drain_last_s);
  assign last_round_o = ((state_q == ST_ROUND) || (state_q == ST_DRAIN)) && (round_q == nr_s);
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign out_valid_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: per-cycle expected output timeline.
module tb_aes_round_ctrl;

  localparam int D = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic       key_ready;
  logic [3:0] key_round;
  logic [3:0] round;
  logic [3:0] width_sel;
  logic       load_sel;
  logic       state_we;
  logic       last_round;
  logic       busy;
  logic       out_valid;
  logic       out_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_total = 0;
  int ls_total = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .mode_i       (mode),
    .key_ready_i  (key_ready),
    .key_round_o  (key_round),
    .round_o      (round),
    .width_sel_o  (width_sel),
    .load_sel_o   (load_sel),
    .state_we_o   (state_we),
    .last_round_o (last_round),
    .busy_o       (busy),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (state_we) we_total++;
    if (load_sel) ls_total++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic ir, input logic [3:0] kr,
                             input logic [3:0] rnd, input logic [3:0] ws, input logic ls,
                             input logic we, input logic lr, input logic bsy, input logic ov);
    logic [17:0] obs;
    logic [17:0] exp;
    obs = {in_ready, key_round, round, width_sel, load_sel, state_we, last_round, busy, out_valid};
    exp = {ir, kr, rnd, ws, ls, we, lr, bsy, ov};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic run_block(input logic [1:0] m, input logic [1:0] mid_m, input int nr,
                           input int lat, input int stall_r, input int done_stall);
    int we0;
    int ls0;
    int nstall;
    logic [3:0] rr;
    logic lr;
    expect_outs("idle_before", 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    we0 = we_total;
    ls0 = ls_total;
    mode = m;
    in_valid = 1'b1;
    cyc = 0;
    step();
    in_valid = 1'b0;
    mode = mid_m;
    expect_outs("kwait_r0", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    expect_outs("init", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    for (int r = 1; r <= nr; r++) begin
      rr = 4'(r);
      lr = (r == nr);
      nstall = (r == stall_r) ? 5 : 0;
      for (int s = 0; s <= nstall; s++) begin
        expect_outs("kwait", 1'b0, rr, rr, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        key_ready = (s < nstall) ? 1'b0 : 1'b1;
        step();
      end
      for (int w = 0; w < 16; w++) begin
        expect_outs("round", 1'b0, 4'd0, rr, 4'(w), 1'b0, 1'b0, lr, 1'b1, 1'b0);
        key_ready = (w != 7);
        step();
      end
      for (int d = 0; d < D; d++) begin
        expect_outs("drain", 1'b0, 4'd0, rr, 4'd0, 1'b0, (d == D - 1), lr, 1'b1, 1'b0);
        step();
      end
    end
    chk_int("latency", cyc, lat);
    expect_outs("done", 1'b0, 4'd0, 4'(nr), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (done_stall > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      mode = 2'b00;
    end
    for (int s = 0; s < done_stall; s++) begin
      step();
      expect_outs("done_hold", 1'b0, 4'd0, 4'(nr), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (s == done_stall - 1) out_ready = 1'b1;
    end
    step();
    expect_outs("idle_after", 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_int("state_we_pulses", we_total - we0, nr + 1);
    chk_int("load_sel_pulses", ls_total - ls0, 1);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    in_valid = 1'b0;
    mode = 2'b00;
    key_ready = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    expect_outs("reset", 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    run_block(2'b00, 2'b00, 10, 183, 0, 0);
    run_block(2'b01, 2'b00, 12, 219, 0, 0);
    run_block(2'b10, 2'b00, 14, 255, 0, 0);
    run_block(2'b11, 2'b01, 14, 255, 0, 0);
    // Key stall at round 3, then a DONE stall with a pending block behind it.
    run_block(2'b00, 2'b10, 10, 188, 3, 4);
    run_block(2'b00, 2'b00, 10, 183, 0, 0);

    // Abort mid-block with reset at round 5, sub-step 7.
    mode = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!(round == 4'd5 && width_sel == 4'd7) && k < 300) begin
      step();
      k++;
    end
    chk_int("reach_r5_w7", int'(round == 4'd5 && width_sel == 4'd7), 1);
    reset = 1'b1;
    step();
    expect_outs("reset_abort", 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    run_block(2'b00, 2'b00, 10, 183, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
